// File: rtl/bytebeat_pkg.sv
// bytebeat_pkg: shared sample width, PWM period and sample type for the bytebeat audio path
package bytebeat_pkg;
  localparam int DEF_SAMPLE_W = 8;
  localparam int PWM_PERIOD = 2 ** DEF_SAMPLE_W;
  typedef logic [DEF_SAMPLE_W-1:0] sample_t;
endpackage

// File: rtl/bytebeat_pwm_if.sv
// bytebeat_pwm_if: rdy/vld sample channel from the bytebeat generator into the PWM stage
interface bytebeat_pwm_if import bytebeat_pkg::*; #(parameter int SAMPLE_W = DEF_SAMPLE_W);
  logic [SAMPLE_W-1:0] pwm__sample_r;
  logic pwm__sample_r_vld;
  logic pwm__sample_r_rdy;
  modport master (output pwm__sample_r, output pwm__sample_r_vld, input pwm__sample_r_rdy);
  modport slave (input pwm__sample_r, input pwm__sample_r_vld, output pwm__sample_r_rdy);
endinterface

// File: rtl/bytebeat_tick_gen.sv
// bytebeat_tick_gen: prescaler producing one counter tick every PRESCALE enabled clocks
module bytebeat_tick_gen #(
  parameter int PRESCALE = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  output logic tick
);
  localparam int PW = PRESCALE > 1 ? $clog2(PRESCALE) : 1;
  logic [PW-1:0] pre_cnt_q, pre_cnt_d;
  assign tick = enable && pre_cnt_q == PW'(PRESCALE - 1);
  always_comb pre_cnt_d = tick ? '0 : enable ? pre_cnt_q + PW'(1) : pre_cnt_q;
  always_ff @(posedge clk or posedge reset)
    if (reset) pre_cnt_q <= '0;
    else pre_cnt_q <= pre_cnt_d;
endmodule

// File: rtl/bytebeat_pwm.sv
// bytebeat_pwm: one-entry sample buffer feeding a PWM period counter, one sample per period
module bytebeat_pwm import bytebeat_pkg::*; #(
  parameter int SAMPLE_W = DEF_SAMPLE_W,
  parameter int PRESCALE = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  bytebeat_pwm_if.slave      smp,
  output logic               pwm_out,
  output logic               sample_strobe,
  output logic               underrun
);
  logic                tick, boundary, xfer;
  logic [SAMPLE_W-1:0] cnt_q, cnt_d, buf_q, buf_d, active_q, active_d;
  logic                buf_full_q, buf_full_d, pwm_q, pwm_d, strobe_q, strobe_d, underrun_q, underrun_d;
  bytebeat_tick_gen #(.PRESCALE(PRESCALE)) u_tick (
    .clk    (clk),
    .reset  (reset),
    .enable (enable),
    .tick   (tick)
  );
  assign smp.pwm__sample_r_rdy = !buf_full_q && !reset;
  assign xfer = smp.pwm__sample_r_vld && smp.pwm__sample_r_rdy;
  assign boundary = tick && (&cnt_q);
  // transfer needs an empty buffer and load needs a full one, so they never collide
  always_comb begin
    cnt_d      = tick ? cnt_q + SAMPLE_W'(1) : cnt_q;
    buf_d      = xfer ? smp.pwm__sample_r : buf_q;
    buf_full_d = xfer || (buf_full_q && !boundary);
    active_d   = (boundary && buf_full_q) ? buf_q : active_q;
    pwm_d      = enable && (cnt_q < active_q);
    strobe_d   = boundary && buf_full_q;
    underrun_d = boundary && !buf_full_q;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      cnt_q      <= '0;
      buf_q      <= '0;
      buf_full_q <= 1'b0;
      active_q   <= '0;
      pwm_q      <= 1'b0;
      strobe_q   <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      buf_q      <= buf_d;
      buf_full_q <= buf_full_d;
      active_q   <= active_d;
      pwm_q      <= pwm_d;
      strobe_q   <= strobe_d;
      underrun_q <= underrun_d;
    end
  assign pwm_out       = pwm_q;
  assign sample_strobe = strobe_q;
  assign underrun      = underrun_q;
endmodule

// File: tb/tb_bytebeat_pwm.sv
// tb_bytebeat_pwm: directed scoreboard bench; monitors check duty and length of every PWM period
module tb_bytebeat_pwm;
  import bytebeat_pkg::*;
  logic clk = 1'b0;
  logic reset, en1, en4;
  logic pwm1, strb1, und1, pwm4, strb4, und4;
  bytebeat_pwm_if a1 ();
  bytebeat_pwm_if a4 ();
  bytebeat_pwm #(.PRESCALE(1)) dut1 (
    .clk(clk), .reset(reset), .enable(en1), .smp(a1),
    .pwm_out(pwm1), .sample_strobe(strb1), .underrun(und1)
  );
  bytebeat_pwm #(.PRESCALE(4)) dut4 (
    .clk(clk), .reset(reset), .enable(en4), .smp(a4),
    .pwm_out(pwm4), .sample_strobe(strb4), .underrun(und4)
  );
  always #5 clk = ~clk;
  int checks = 0, failures = 0;
  sample_t q1[$], q4[$];
  int ev1 = 0, ns1 = 0, nu1 = 0, h1 = 0, l1 = 0, d1 = 0, act1 = 0;
  int ev4 = 0, ns4 = 0, nu4 = 0, h4 = 0, l4 = 0, act4 = 0;
  bit first1 = 1'b1, first4 = 1'b1;
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  // each strobe/underrun closes a period: check its high count and length, then move on
  always @(negedge clk) begin
    if (reset) begin
      first1 = 1'b1; h1 = 0; l1 = 0; d1 = 0; act1 = 0;
    end else begin
      h1 += int'(pwm1); l1++;
      if (!en1) d1++;
      if (strb1 || und1) begin
        if (!first1) begin
          chk("period_highs_p1", h1, act1);
          chk("period_len_p1", l1, PWM_PERIOD + d1);
        end
        if (strb1 && und1) chk("both_pulses_p1", 1, 0);
        if (strb1) begin
          ns1++;
          if (q1.size() == 0) chk("unexpected_strobe_p1", 1, 0);
          else act1 = int'(q1.pop_front());
        end
        if (und1) nu1++;
        ev1++; first1 = 1'b0; h1 = 0; l1 = 0; d1 = 0;
      end
    end
  end
  always @(negedge clk) begin
    if (reset) begin
      first4 = 1'b1; h4 = 0; l4 = 0; act4 = 0;
    end else begin
      h4 += int'(pwm4); l4++;
      if (strb4 || und4) begin
        if (!first4) begin
          chk("period_highs_p4", h4, act4 * 4);
          chk("period_len_p4", l4, PWM_PERIOD * 4);
        end
        if (strb4) begin
          ns4++;
          if (q4.size() == 0) chk("unexpected_strobe_p4", 1, 0);
          else act4 = int'(q4.pop_front());
        end
        if (und4) nu4++;
        ev4++; first4 = 1'b0; h4 = 0; l4 = 0;
      end
    end
  end
  task automatic send(input bit w, input sample_t d);
    for (int i = 0; i < 3000; i++) begin
      if (w) begin a4.pwm__sample_r_vld = 1'b1; a4.pwm__sample_r = d; end
      else begin a1.pwm__sample_r_vld = 1'b1; a1.pwm__sample_r = d; end
      @(negedge clk);
      if ((w ? a4.pwm__sample_r_rdy : a1.pwm__sample_r_rdy) === 1'b1) begin
        if (w) q4.push_back(d);
        else q1.push_back(d);
        @(posedge clk); #1;
        return;
      end
      @(posedge clk); #1;
    end
    chk(w ? "send_timeout_p4" : "send_timeout_p1", 0, 1);
  endtask
  task automatic idle(input bit w);
    if (w) a4.pwm__sample_r_vld = 1'b0;
    else a1.pwm__sample_r_vld = 1'b0;
  endtask
  task automatic wait_ev(input bit w, input int n);
    int tgt;
    tgt = (w ? ev4 : ev1) + n;
    for (int i = 0; i < n * 2200; i++) begin
      @(posedge clk);
      if ((w ? ev4 : ev1) >= tgt) begin #1; return; end
    end
    chk(w ? "event_timeout_p4" : "event_timeout_p1", 0, 1);
  endtask
  initial begin
    int s0, u0, e0;
    reset = 1'b1; en1 = 1'b1; en4 = 1'b1;
    a1.pwm__sample_r_vld = 1'b0; a1.pwm__sample_r = '0;
    a4.pwm__sample_r_vld = 1'b0; a4.pwm__sample_r = '0;
    repeat (3) @(negedge clk);
    chk("reset_rdy", a1.pwm__sample_r_rdy, 0);
    chk("reset_pwm", pwm1, 0);
    chk("reset_strobe", strb1, 0);
    chk("reset_underrun", und1, 0);
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    chk("release_rdy", a1.pwm__sample_r_rdy, 1);
    @(posedge clk); #1;
    // half duty, strobe at the first boundary
    send(0, 8'h80); idle(0);
    wait_ev(0, 1);
    chk("t1_first_strobe", ns1, 1);
    chk("t1_no_underrun", nu1, 0);
    wait_ev(0, 2);
    // duty extremes
    send(0, 8'h00); send(0, 8'hFF); idle(0);
    wait_ev(0, 2);
    // back-to-back with vld held high
    @(negedge clk);
    chk("t3_rdy_empty", a1.pwm__sample_r_rdy, 1);
    @(posedge clk); #1;
    send(0, 8'h10);
    chk("t3_rdy_low_full", a1.pwm__sample_r_rdy, 0);
    send(0, 8'h20); send(0, 8'h30); idle(0);
    wait_ev(0, 2);
    // single sample then starvation
    send(0, 8'h40); idle(0);
    wait_ev(0, 1);
    u0 = nu1;
    wait_ev(0, 3);
    chk("t4_underruns", nu1 - u0, 3);
    // enable low stretches the period
    repeat (50) @(posedge clk); #1;
    chk("pre_disable_pwm", pwm1, 1);
    e0 = ev1; en1 = 1'b0;
    repeat (50) @(negedge clk);
    chk("disabled_pwm", pwm1, 0);
    repeat (50) @(posedge clk); #1 en1 = 1'b1;
    chk("disabled_no_event", ev1 - e0, 0);
    wait_ev(0, 1);
    // async reset with a full buffer
    repeat (10) @(posedge clk); #1;
    send(0, 8'h55); idle(0);
    chk("pre_reset_rdy", a1.pwm__sample_r_rdy, 0);
    chk("pre_reset_pwm", pwm1, 1);
    reset = 1'b1; q1.delete(); q4.delete();
    #1;
    chk("reset_now_pwm", pwm1, 0);
    chk("reset_now_rdy", a1.pwm__sample_r_rdy, 0);
    repeat (2) @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    chk("post_reset_rdy", a1.pwm__sample_r_rdy, 1);
    s0 = ns1; u0 = nu1;
    @(posedge clk); #1;
    wait_ev(0, 1);
    chk("post_reset_no_strobe", ns1 - s0, 0);
    chk("post_reset_underrun", nu1 - u0, 1);
    // prescaled instance
    send(1, 8'h40); idle(1);
    wait_ev(1, 1);
    chk("t5_strobe", ns4, 1);
    wait_ev(1, 2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
